// File: rtl/hdlc_ctrl.sv
// Register-bus master sequencing the Hdlc core: host TX stream -> Tx_Buff/Tx_Enable, Rx_SC polling -> host RX stream.
// Optional macro HDLC_CTRL_RX_DROP_EN: errored RX frames are dropped via Rx_Drop instead of being drained.
module hdlc_ctrl #(
    parameter int unsigned MAX_TX_BYTES  = 126,
    parameter int unsigned POLL_INTERVAL = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    output logic [2:0] Address,
    output logic       WriteEnable,
    output logic       ReadEnable,
    output logic [7:0] DataIn,
    input  logic [7:0] DataOut,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       tx_abort,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_last,
    input  logic       rx_ready,
    output logic       tx_err,
    output logic       rx_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(MAX_TX_BYTES + 1);
    localparam int unsigned PW = $clog2(POLL_INTERVAL + 1);
    localparam logic [CW-1:0] TX_LAST_IDX = CW'(MAX_TX_BYTES - 1);
    localparam logic [PW-1:0] POLL_DUE    = PW'(POLL_INTERVAL - 1);

    typedef enum logic [3:0] {
        IDLE, TX_POLL, TX_PWAIT, TX_WR, TX_GO, RX_POLL, RX_PWAIT,
        RX_LEN, RX_LWAIT, RX_RD, RX_RWAIT, RX_OUT, ABORT, RX_DROP
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_poll_cnt;
    logic          r_rr_rx;
    logic [CW-1:0] r_tx_cnt;
    logic          r_tx_drop;
    logic          r_abort_pend;
    logic          r_err_pend;
    logic [7:0]    r_len;
    logic [7:0]    r_idx;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_rx_last;
    logic          r_tx_err;
    logic          r_rx_err;

    logic w_tx_cand;
    logic w_rx_cand;
    logic w_grant_rx;
    logic w_tx_acc;

    assign w_tx_cand  = tx_valid;
    assign w_rx_cand  = (r_poll_cnt == POLL_DUE);
    assign w_grant_rx = w_rx_cand && (!w_tx_cand || r_rr_rx);
    assign w_tx_acc   = (r_state == TX_WR) && tx_valid && !tx_abort;

    assign tx_ready = (r_state == TX_WR);
    assign busy     = (r_state != IDLE);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_last  = r_rx_last;
    assign tx_err   = r_tx_err;
    assign rx_err   = r_rx_err;

    // Strobes are decoded from the state register; only the TX_WR write also depends on the live handshake.
    always_comb begin
        Address     = '0;
        WriteEnable = 1'b0;
        ReadEnable  = 1'b0;
        DataIn      = '0;
        case (r_state)
            TX_POLL: ReadEnable = 1'b1;
            TX_WR: begin
                Address = 3'd1;
                if (w_tx_acc && !r_tx_drop) begin
                    WriteEnable = 1'b1;
                    DataIn      = tx_data;
                end
            end
            TX_GO:   begin WriteEnable = 1'b1; DataIn = 8'h02; end
            ABORT:   begin WriteEnable = 1'b1; DataIn = 8'h04; end
            RX_POLL: begin ReadEnable = 1'b1; Address = 3'd2; end
            RX_DROP: begin WriteEnable = 1'b1; Address = 3'd2; DataIn = 8'h02; end
            RX_LEN:  begin ReadEnable = 1'b1; Address = 3'd4; end
            RX_RD:   begin ReadEnable = 1'b1; Address = 3'd3; end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_poll_cnt   <= '0;
            r_rr_rx      <= 1'b0;
            r_tx_cnt     <= '0;
            r_tx_drop    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_err_pend   <= 1'b0;
            r_len        <= '0;
            r_idx        <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_last    <= 1'b0;
            r_tx_err     <= 1'b0;
            r_rx_err     <= 1'b0;
        end else begin
            r_tx_err <= 1'b0;
            r_rx_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_abort || r_abort_pend) begin
                        r_state      <= ABORT;
                        r_abort_pend <= 1'b0;
                    end else if (w_tx_cand || w_rx_cand) begin
                        r_rr_rx <= !w_grant_rx;
                        if (w_grant_rx) begin
                            r_state    <= RX_POLL;
                            r_poll_cnt <= '0;
                        end else begin
                            r_state <= TX_POLL;
                        end
                    end else begin
                        r_poll_cnt <= r_poll_cnt + PW'(1);
                    end
                end
                TX_POLL:  r_state <= tx_abort ? ABORT : TX_PWAIT;
                TX_PWAIT: begin
                    if (tx_abort) r_state <= ABORT;
                    else if (DataOut[0]) begin
                        r_state   <= TX_WR;
                        r_tx_cnt  <= '0;
                        r_tx_drop <= 1'b0;
                    end else r_state <= TX_POLL;
                end
                TX_WR: begin
                    if (tx_abort) begin
                        r_state   <= ABORT;
                        r_tx_drop <= 1'b0;
                    end else if (tx_valid) begin
                        if (!r_tx_drop) begin
                            r_tx_cnt <= r_tx_cnt + CW'(1);
                            if (r_tx_cnt == TX_LAST_IDX && !tx_last) begin
                                r_tx_err  <= 1'b1;
                                r_tx_drop <= 1'b1;
                            end
                        end
                        if (tx_last) begin
                            r_state   <= TX_GO;
                            r_tx_drop <= 1'b0;
                        end
                    end
                end
                TX_GO:    r_state <= tx_abort ? ABORT : IDLE;
                ABORT:    r_state <= IDLE;
                default: begin
                    // Every remaining state is an RX state: aborts wait until IDLE.
                    if (tx_abort) r_abort_pend <= 1'b1;
                    case (r_state)
                        RX_POLL:  r_state <= RX_PWAIT;
                        RX_PWAIT: begin
                            if (!DataOut[0]) r_state <= IDLE;
                            else if (|DataOut[4:2]) begin
`ifdef HDLC_CTRL_RX_DROP_EN
                                r_rx_err <= 1'b1;
                                r_state  <= RX_DROP;
`else
                                r_err_pend <= 1'b1;
                                r_state    <= RX_LEN;
`endif
                            end else r_state <= RX_LEN;
                        end
                        RX_DROP:  r_state <= IDLE;
                        RX_LEN:   r_state <= RX_LWAIT;
                        RX_LWAIT: begin
                            r_len <= DataOut;
                            r_idx <= '0;
                            if (DataOut == 8'd0) begin
                                r_state    <= IDLE;
                                r_rx_err   <= r_err_pend;
                                r_err_pend <= 1'b0;
                            end else r_state <= RX_RD;
                        end
                        RX_RD:    r_state <= RX_RWAIT;
                        RX_RWAIT: begin
                            r_rx_data  <= DataOut;
                            r_rx_valid <= 1'b1;
                            r_rx_last  <= (r_idx + 8'd1 == r_len);
                            r_idx      <= r_idx + 8'd1;
                            r_rx_err   <= r_err_pend;
                            r_err_pend <= 1'b0;
                            r_state    <= RX_OUT;
                        end
                        RX_OUT: begin
                            if (rx_ready) begin
                                r_rx_valid <= 1'b0;
                                r_rx_last  <= 1'b0;
                                r_state    <= (r_idx == r_len) ? IDLE : RX_RD;
                            end
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            endcase
        end
    end

endmodule
